// File: rtl/plms_error_calc.sv
`default_nettype none
// ============================================================================
// Module      : plms_error_calc
// Description : PLMS complex error e = mu*(d_delayed - y), 2-stage saturating
//               pipeline plus training-burst FSM that tags samples for update.
// Revision    : 1.0 - initial release
// ============================================================================
module plms_error_calc #(
    parameter int W         = 18,
    parameter int TRAIN_LEN = 256,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 din_valid,
    input  logic signed [W-1:0]  dI,
    input  logic signed [W-1:0]  dQ,
    input  logic signed [W-1:0]  yI,
    input  logic signed [W-1:0]  yQ,
    input  logic        [2:0]    mu_shift,
    output logic signed [W-1:0]  eI,
    output logic signed [W-1:0]  eQ,
    output logic                 e_valid,
    output logic                 upd_en,
    output logic                 train_done,
    output logic [CNT_W-1:0]     sample_cnt
);

    localparam logic [1:0]       c_idle  = 2'd0;
    localparam logic [1:0]       c_train = 2'd1;
    localparam logic [1:0]       c_done  = 2'd2;
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(TRAIN_LEN - 1);

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_done;

    logic [1:0]             w_state_eff;
    logic [CNT_W-1:0]       w_cnt_eff;
    logic [1:0]             w_state_nx;
    logic [CNT_W-1:0]       w_cnt_nx;
    logic                   w_done_nx;
    logic                   w_tag;

    logic signed [W:0]      w_diff_i;
    logic signed [W:0]      w_diff_q;
    logic signed [W:0]      r_diff_i;
    logic signed [W:0]      r_diff_q;
    logic [2:0]             r_mu;
    logic                   r_tag;
    logic                   r_s1_valid;

    logic signed [W:0]      w_sh_i;
    logic signed [W:0]      w_sh_q;

    logic signed [W-1:0]    r_e_i;
    logic signed [W-1:0]    r_e_q;
    logic                   r_e_valid;
    logic                   r_upd_en;

    function automatic logic signed [W-1:0] sat(input logic signed [W:0] v);
        if (v[W] != v[W-1])
            sat = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            sat = v[W-1:0];
    endfunction

    // A start in the same cycle is applied first, so the sample it arrives
    // with is counted as the first of the new burst.
    always_comb begin
        w_state_eff = start ? c_train : r_state;
        w_cnt_eff   = start ? '0 : r_cnt;
        w_state_nx  = w_state_eff;
        w_cnt_nx    = w_cnt_eff;
        w_done_nx   = start ? 1'b0 : r_done;
        w_tag       = (w_state_eff == c_train);
        case (w_state_eff)
            c_idle: begin
                w_cnt_nx = '0;
            end
            c_train: begin
                if (din_valid) begin
                    w_cnt_nx = w_cnt_eff + 1'b1;
                    if (w_cnt_eff == c_last) begin
                        w_state_nx = c_done;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            c_done: begin
                w_state_nx = c_done;
            end
            default: begin
                w_state_nx = c_idle;
                w_cnt_nx   = '0;
                w_done_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_done  <= w_done_nx;
        end
    end

    // One guard bit makes the difference exact.
    assign w_diff_i = {dI[W-1], dI} - {yI[W-1], yI};
    assign w_diff_q = {dQ[W-1], dQ} - {yQ[W-1], yQ};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_diff_i   <= '0;
            r_diff_q   <= '0;
            r_mu       <= '0;
            r_tag      <= 1'b0;
        end else begin
            r_s1_valid <= din_valid;
            if (din_valid) begin
                r_diff_i <= w_diff_i;
                r_diff_q <= w_diff_q;
                r_mu     <= mu_shift;
                r_tag    <= w_tag;
            end
        end
    end

    assign w_sh_i = r_diff_i >>> r_mu;
    assign w_sh_q = r_diff_q >>> r_mu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_i     <= '0;
            r_e_q     <= '0;
            r_e_valid <= 1'b0;
            r_upd_en  <= 1'b0;
        end else begin
            r_e_valid <= r_s1_valid;
            r_upd_en  <= r_s1_valid & r_tag;
            if (r_s1_valid) begin
                r_e_i <= sat(w_sh_i);
                r_e_q <= sat(w_sh_q);
            end
        end
    end

    assign eI         = r_e_i;
    assign eQ         = r_e_q;
    assign e_valid    = r_e_valid;
    assign upd_en     = r_upd_en;
    assign train_done = r_done;
    assign sample_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_plms_error_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_plms_error_calc
// Description : Directed self-checking bench for plms_error_calc (TRAIN_LEN=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plms_error_calc;

    localparam int c_w     = 18;
    localparam int c_cnt_w = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    din_valid = 1'b0;
    logic signed [c_w-1:0]   dI = '0;
    logic signed [c_w-1:0]   dQ = '0;
    logic signed [c_w-1:0]   yI = '0;
    logic signed [c_w-1:0]   yQ = '0;
    logic [2:0]              mu_shift = '0;
    logic signed [c_w-1:0]   eI;
    logic signed [c_w-1:0]   eQ;
    logic                    e_valid;
    logic                    upd_en;
    logic                    train_done;
    logic [c_cnt_w-1:0]      sample_cnt;

    int n_total = 0;
    int n_bad   = 0;

    plms_error_calc #(
        .W         (c_w),
        .TRAIN_LEN (4),
        .CNT_W     (c_cnt_w)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din_valid  (din_valid),
        .dI         (dI),
        .dQ         (dQ),
        .yI         (yI),
        .yQ         (yQ),
        .mu_shift   (mu_shift),
        .eI         (eI),
        .eQ         (eQ),
        .e_valid    (e_valid),
        .upd_en     (upd_en),
        .train_done (train_done),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int di, input int yi, input int dq, input int yq, input int mu);
        din_valid = 1'b1;
        dI        = di[c_w-1:0];
        yI        = yi[c_w-1:0];
        dQ        = dq[c_w-1:0];
        yQ        = yq[c_w-1:0];
        mu_shift  = mu[2:0];
    endtask

    initial begin
        #2;
        chk("rst_e_valid", int'(e_valid), 0);
        chk("rst_eI", int'(eI), 0);
        chk("rst_cnt", int'(sample_cnt), 0);
        chk("rst_done", int'(train_done), 0);
        tick;
        rst = 1'b0;
        tick;

        // Basic scaled error in IDLE: no update permission.
        drive(1000, 400, -500, 500, 2);
        tick;
        din_valid = 1'b0;
        chk("lat1_e_valid", int'(e_valid), 0);
        tick;
        chk("basic_e_valid", int'(e_valid), 1);
        chk("basic_eI", int'(eI), 150);
        chk("basic_eQ", int'(eQ), -250);
        chk("basic_upd", int'(upd_en), 0);
        tick;
        chk("hold_e_valid", int'(e_valid), 0);
        chk("hold_eI", int'(eI), 150);
        chk("hold_eQ", int'(eQ), -250);

        // Saturation at both rails.
        drive(131071, -131072, -131072, 131071, 0);
        tick;
        din_valid = 1'b0;
        tick;
        chk("sat_eI", int'(eI), 131071);
        chk("sat_eQ", int'(eQ), -131072);

        // Arithmetic shift floors toward -inf.
        drive(-3, 0, 0, 0, 1);
        tick;
        din_valid = 1'b0;
        tick;
        chk("floor_eI", int'(eI), -2);
        chk("floor_eQ", int'(eQ), 0);

        // Training burst of 4, six back-to-back samples.
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_cnt", int'(sample_cnt), 0);
        chk("start_done", int'(train_done), 0);
        for (int k = 0; k < 8; k++) begin
            if (k < 6) drive(k * 10, 0, 0, 0, 0);
            else din_valid = 1'b0;
            tick;
            chk($sformatf("burst_cnt_%0d", k), int'(sample_cnt), (k + 1 < 4) ? k + 1 : 4);
            chk($sformatf("burst_done_%0d", k), int'(train_done), (k >= 3) ? 1 : 0);
            chk($sformatf("burst_ev_%0d", k), int'(e_valid), (k >= 1 && k <= 6) ? 1 : 0);
            chk($sformatf("burst_upd_%0d", k), int'(upd_en), (k >= 1 && k <= 4) ? 1 : 0);
            if (k >= 1)
                chk($sformatf("burst_eI_%0d", k), int'(eI), ((k - 1 < 5) ? k - 1 : 5) * 10);
        end

        // Reset one cycle after a valid input: it must never emerge.
        drive(77, 0, 33, 0, 0);
        tick;
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_e_valid", int'(e_valid), 0);
        chk("arst_eI", int'(eI), 0);
        chk("arst_upd", int'(upd_en), 0);
        chk("arst_cnt", int'(sample_cnt), 0);
        chk("arst_done", int'(train_done), 0);
        tick;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("arst_drop_%0d", k), int'(e_valid), 0);
        end
        chk("arst_idle_cnt", int'(sample_cnt), 0);

        // Restart mid-burst with a coincident valid sample.
        start = 1'b1;
        tick;
        start = 1'b0;
        drive(5, 0, 0, 0, 0);
        tick;
        tick;
        chk("pre_restart_cnt", int'(sample_cnt), 2);
        start = 1'b1;
        tick;
        start = 1'b0;
        din_valid = 1'b0;
        chk("restart_cnt", int'(sample_cnt), 1);
        chk("restart_done", int'(train_done), 0);
        chk("restart_upd_old", int'(upd_en), 1);
        tick;
        chk("restart_upd_new", int'(upd_en), 1);
        tick;
        chk("restart_tail_ev", int'(e_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plms_error_calc.md
Name: plms_error_calc

Overview:
- Downstream consumer of the delayed desired-signal stage in the PLMS adaptive beamformer.
- Forms the complex error e = mu * (d_delayed - y), where d_delayed is the delayed desired-signal sample pair and y is the beamformer output sample pair.
- Error path: 2-stage pipeline with saturation.
- Training FSM: counts training samples; its update-enable flag travels with each error sample into the weight-update block.

Parameters:
- W, 18, sample width of all I/Q data in and out (signed two's complement)
- TRAIN_LEN, 256, number of valid samples per training burst (>=1)
- CNT_W, 16, width of sample counter (2^CNT_W > TRAIN_LEN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins or restarts a training burst
- din_valid  in  1  dI/dQ/yI/yQ valid this cycle
- dI  in  W  delayed desired sample, I (signed)
- dQ  in  W  delayed desired sample, Q (signed)
- yI  in  W  beamformer output, I (signed)
- yQ  in  W  beamformer output, Q (signed)
- mu_shift  in  3  step size as right shift, mu = 2^-mu_shift; sampled with din_valid
- eI  out  W  scaled error, I (signed)
- eQ  out  W  scaled error, Q (signed)
- e_valid  out  1  eI/eQ valid
- upd_en  out  1  weight update permitted for this error sample; qualified by e_valid
- train_done  out  1  sticky: burst completed
- sample_cnt  out  CNT_W  training samples accepted in current burst

Behaviour:
- Reset (async, rst=1): all of the following clear immediately:
  - eI, eQ, e_valid, upd_en, train_done, sample_cnt, all pipeline registers.
  - FSM goes to IDLE.
- Stage 1, on din_valid:
  - diffI = dI - yI and diffQ = dQ - yQ at W+1 bits, sign-extended, no overflow.
  - Register diffI, diffQ, mu_shift, and tag = (state==TRAIN after any start this cycle is applied).
- Stage 2:
  - Arithmetic right shift of diff by mu_shift (truncate toward -inf).
  - Saturate to W bits: max 2^(W-1)-1, min -2^(W-1). Saturation only possible when mu_shift=0.
  - Register result to eI/eQ; upd_en = tag.
- Latency: e_valid asserts exactly 2 cycles after din_valid.
  - Back-to-back valids give back-to-back outputs; no stalls, no backpressure.
  - Error path is computed in every FSM state.
- e_valid=0 cycles:
  - eI/eQ hold their last value.
  - upd_en forced 0.
- FSM states: IDLE, TRAIN, DONE.
  - IDLE: sample_cnt=0. start -> TRAIN.
  - TRAIN: each din_valid increments sample_cnt. On a din_valid with sample_cnt==TRAIN_LEN-1 -> DONE, train_done=1, sample_cnt=TRAIN_LEN. That last sample carries tag=1.
  - DONE: holds sample_cnt and train_done. start -> TRAIN.
- start in any state: sample_cnt=0, train_done=0, state TRAIN.
- start together with din_valid: that sample is counted as sample 1 (cnt=1) and carries tag=1.
  - If TRAIN_LEN=1, go straight to DONE.
- start during TRAIN: restart the count. Samples already in the pipeline keep their tags.
- Reset mid-burst: in-flight samples are dropped (no e_valid) and FSM returns to IDLE.

Test Plan:
- Reset, then din_valid with dI=1000, yI=400, dQ=-500, yQ=500, mu_shift=2 -> 2 cycles later e_valid=1, eI=150, eQ=-250, upd_en=0 (IDLE).
- mu_shift=0, dI=131071, yI=-131072; dQ=-131072, yQ=131071 -> eI=131071, eQ=-131072 (both saturated).
- mu_shift=1, dI=-3, yI=0 -> eI=-2 (floor of -1.5).
- TRAIN_LEN=4: start pulse, then 6 consecutive valids ->
  - upd_en=1 on output samples 1-4, 0 on samples 5-6.
  - train_done rises after sample 4 is accepted; sample_cnt stops at 4.
- start during TRAIN at sample_cnt=2 with din_valid high -> sample_cnt=1 next cycle, train_done stays 0.
- rst asserted 1 cycle after a valid input -> e_valid never pulses for it; all outputs 0 immediately.
